// File: rtl/riscv_rrmux_if.sv
// Channel-side and sink-side bundle of the arbitrated mux. Signal names keep
// the block's established i_/o_ port naming so existing integrations map 1:1.
interface riscv_rrmux_if #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  logic                      i_riscv_rrmux_mode;
  logic [SELW-1:0]           i_riscv_rrmux_sel;
  logic [CHANNELS-1:0]       i_riscv_rrmux_valid;
  logic [CHANNELS*WIDTH-1:0] i_riscv_rrmux_data;
  logic [CHANNELS-1:0]       o_riscv_rrmux_ready;
  logic                      o_riscv_rrmux_valid;
  logic [WIDTH-1:0]          o_riscv_rrmux_data;
  logic [SELW-1:0]           o_riscv_rrmux_chan;
  logic                      i_riscv_rrmux_ready;

  // Producers plus downstream sink, i.e. everything around the mux.
  modport master (
    output i_riscv_rrmux_mode, i_riscv_rrmux_sel, i_riscv_rrmux_valid,
           i_riscv_rrmux_data, i_riscv_rrmux_ready,
    input  o_riscv_rrmux_ready, o_riscv_rrmux_valid, o_riscv_rrmux_data,
           o_riscv_rrmux_chan
  );

  // The mux itself.
  modport slave (
    input  i_riscv_rrmux_mode, i_riscv_rrmux_sel, i_riscv_rrmux_valid,
           i_riscv_rrmux_data, i_riscv_rrmux_ready,
    output o_riscv_rrmux_ready, o_riscv_rrmux_valid, o_riscv_rrmux_data,
           o_riscv_rrmux_chan
  );
endinterface

// File: rtl/riscv_rrmux.sv
// N-channel arbitrated mux with a registered output stage. Mode 0 steers by
// an external channel index, mode 1 arbitrates round-robin. One-cycle
// latency; the output register reloads in the same cycle it is drained.
module riscv_rrmux #(
  parameter  int unsigned WIDTH    = 64,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input logic          i_riscv_rrmux_clk,
  input logic          i_riscv_rrmux_rst,
  riscv_rrmux_if.slave bus
);

  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    data_q,  data_d;
  logic [SELW-1:0]     chan_q,  chan_d;
  logic [SELW-1:0]     ptr_q,   ptr_d;

  logic                load;
  logic                sel_ok;
  logic                rr_found;
  logic [SELW-1:0]     rr_grant;
  int                  rr_idx;
  logic [SELW-1:0]     grant;
  logic                grant_valid;
  logic                transfer;
  logic [CHANNELS-1:0] ready_d;

  // A select value can only be out of range when CHANNELS is not a power of two.
  if ((1 << SELW) == CHANNELS) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = ({1'b0, bus.i_riscv_rrmux_sel} < (SELW+1)'(CHANNELS));
  end

  // Round-robin search: first valid channel at or after ptr, wrapping at CHANNELS.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path can leave it unassigned and infer a latch.
    rr_found = 1'b0;
    rr_grant = ptr_q;
    rr_idx   = 0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= int'(CHANNELS)) rr_idx = rr_idx - int'(CHANNELS);
      if (!rr_found && bus.i_riscv_rrmux_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = SELW'(rr_idx);
      end
    end
  end

  // Grant selection, accept decode and next state of the output stage.
  always_comb begin
    load = ~valid_q | bus.i_riscv_rrmux_ready;
    if (bus.i_riscv_rrmux_mode) begin
      grant       = rr_grant;
      grant_valid = rr_found;
    end else begin
      grant       = bus.i_riscv_rrmux_sel;
      grant_valid = sel_ok & bus.i_riscv_rrmux_valid[bus.i_riscv_rrmux_sel];
    end
    // Nothing is consumed while reset is held, even though the register is empty.
    transfer = load & grant_valid & ~i_riscv_rrmux_rst;

    ready_d = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      ready_d[k] = transfer & (grant == SELW'(k));
    end

    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = bus.i_riscv_rrmux_data[int'(grant)*WIDTH +: WIDTH];
        chan_d = grant;
      end
    end
    // Only round-robin transfers advance the pointer; it survives mode changes.
    if (bus.i_riscv_rrmux_mode && load && grant_valid) begin
      ptr_d = (int'(grant) == int'(CHANNELS) - 1) ? '0 : grant + SELW'(1);
    end
  end

  // Output register and round-robin pointer, synchronous reset.
  always_ff @(posedge i_riscv_rrmux_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_riscv_rrmux_rst) begin
      // NOTE: the data register is a single output word, not a storage array,
      // and its reset value is observable, so it is reset along with control.
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_riscv_rrmux_ready = ready_d;
  assign bus.o_riscv_rrmux_valid = valid_q;
  assign bus.o_riscv_rrmux_data  = data_q;
  assign bus.o_riscv_rrmux_chan  = chan_q;

endmodule

// File: doc/riscv_rrmux.md
Name: riscv_rrmux

Overview:
- Parametrised N-channel arbitrated multiplexer with a registered output and a valid/ready handshake on every channel.
- Successor to the fixed 4:1 combinational mux. Used where several producers share one datapath sink, e.g. writeback or memory-request merging.
- Two modes: direct select (externally steered) and round-robin (fair arbitration).
- One-cycle latency, full throughput of one transfer per cycle.

Parameters:
- WIDTH, 64, data width per channel.
- CHANNELS, 4, number of input channels. Must be >= 2; need not be a power of two.
- SELW, $clog2(CHANNELS), width of the select and channel-index fields. Derived; never overridden.

Ports:
- i_riscv_rrmux_clk  input  1  clock, rising edge.
- i_riscv_rrmux_rst  input  1  synchronous, active-high reset.
- i_riscv_rrmux_mode  input  1  0 = direct select, 1 = round-robin.
- i_riscv_rrmux_sel  input  SELW  channel index used in mode 0.
- i_riscv_rrmux_valid  input  CHANNELS  per-channel request valid.
- i_riscv_rrmux_data  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- o_riscv_rrmux_ready  output  CHANNELS  per-channel accept; at most one bit set.
- o_riscv_rrmux_valid  output  1  output register holds valid data.
- o_riscv_rrmux_data  output  WIDTH  registered selected data.
- o_riscv_rrmux_chan  output  SELW  index of the channel that produced o_data.
- i_riscv_rrmux_ready  input  1  downstream accept.

Behaviour:
- Reset:
  - Reset is the only clocked priority over everything; all registers use synchronous, active-high reset.
  - On reset: o_valid=0, o_data=0, o_chan=0, round-robin pointer ptr=0.
  - o_ready is combinational and therefore reads all-zero while o_valid=0 and no input is valid.
- Load condition: load = ~o_valid | i_ready. Output register may be overwritten in the same cycle downstream consumes it; no bubble.
- Grant, mode 0:
  - grant_valid = (i_sel < CHANNELS) & i_valid[i_sel]; g = i_sel.
  - Out-of-range i_sel gives no grant.
- Grant, mode 1:
  - g = first k with i_valid[k] set, scanning ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wrap at CHANNELS, not 2^SELW).
  - grant_valid = |i_valid.
- Accept handshake:
  - o_ready[k] = load & grant_valid & (g == k). Combinational; one-hot or zero.
  - A transfer on channel k occurs when i_valid[k] & o_ready[k].
- Clock edge, when load:
  - o_valid <= grant_valid.
  - If grant_valid: o_data <= data[g] and o_chan <= g.
  - If not load: o_valid, o_data and o_chan hold.
- Pointer update:
  - Only on a transfer in mode 1: ptr <= (g == CHANNELS-1) ? 0 : g+1.
  - Mode 0 transfers and idle cycles leave ptr unchanged.
- Stall: while o_valid=1 and i_ready=0:
  - o_data and o_chan are stable.
  - o_ready is all-zero.
  - No input is consumed.
- Source rule: a channel keeps i_valid and its data stable until it sees o_ready. The block may grant a different channel meanwhile.
- Mode switching:
  - Sampled combinationally each cycle; takes effect on the current cycle's grant.
  - ptr is retained across mode changes.
- Fairness (mode 1): a continuously-valid channel is granted within CHANNELS transfers.
- Reset mid-operation: held output data is discarded and o_valid drops on the reset edge. Pending upstream requests are not consumed during reset.
- No combinational path from i_ready to o_valid or o_data. A combinational path exists from i_ready, i_valid, i_sel and mode to o_ready.

Test Plan:
1. Reset: assert rst 2 cycles with all i_valid=1 and i_ready=1 -> o_valid=0, o_data=0, o_chan=0; after release, first transfer is channel 0 (ptr=0) in mode 1.
2. Mode 0: sel=2, valid=4'b0100, data2=64'hAAAA_5555_0000_FFFF, i_ready=1 -> o_ready=4'b0100 that cycle; next cycle o_valid=1, o_data=64'hAAAA_5555_0000_FFFF, o_chan=2.
3. Round-robin, full load: all four channels valid continuously, i_ready=1 -> o_chan sequence 0,1,2,3,0,1 with o_valid=1 every cycle from cycle 1.
4. Backpressure: o_valid=1 with o_chan=1, i_ready=0 for 3 cycles -> o_data/o_chan unchanged and o_ready=0 throughout. When i_ready returns to 1, the next channel (2) is accepted that same cycle.
5. Round-robin, sparse: valid=4'b1010 held, ptr=0, i_ready=1 -> o_chan sequence 1,3,1,3. Switching to mode 0 with sel=3 mid-stream -> only channel 3 is granted and ptr stays frozen.
6. CHANNELS=3 instance:
   - Mode 0 with sel=3 and all valid -> o_ready=0 and o_valid stays 0.
   - Mode 1 -> o_chan wraps 0,1,2,0.
   - Assert rst during a stall -> o_valid=0 on the next edge.
